// File: rtl/conv_window_gen_pkg.sv
// rtl/conv_window_gen_pkg.sv - shared widths and window cell indexing for conv_window_gen
// Purpose: pixel/window widths, counter width and the 3x3 cell-index helper.
// Ports: none (package).
package conv_window_gen_pkg;

  localparam int CELL_BIT = 8;
  localparam int N_CELL   = 9;
  localparam int DIM_BIT  = 6;
  localparam int WIN_BIT  = CELL_BIT * N_CELL;

  // Cell k = 3*r + c; r=0 is the oldest (top) row, c=0 the oldest (left) column.
  function automatic int idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// rtl/conv_window_gen_if.sv - pixel-in / window-out bundle for conv_window_gen
// Purpose: groups control, config, pixel stream and window outputs.
// Ports (signals): start, cfg_width, cfg_height, pix_in, pix_valid (source -> generator);
//                  win_out, win_valid, busy, frame_done, cfg_err (generator -> sink).
interface conv_window_gen_if;
  import conv_window_gen_pkg::*;

  logic                start;
  logic [DIM_BIT-1:0]  cfg_width;
  logic [DIM_BIT-1:0]  cfg_height;
  logic [CELL_BIT-1:0] pix_in;
  logic                pix_valid;
  logic [WIN_BIT-1:0]  win_out;
  logic                win_valid;
  logic                busy;
  logic                frame_done;
  logic                cfg_err;

  modport master (
    output start, cfg_width, cfg_height, pix_in, pix_valid,
    input  win_out, win_valid, busy, frame_done, cfg_err
  );

  modport slave (
    input  start, cfg_width, cfg_height, pix_in, pix_valid,
    output win_out, win_valid, busy, frame_done, cfg_err
  );

endinterface

// File: rtl/conv_line_buffer.sv
// rtl/conv_line_buffer.sv - one image line of pixel storage, read-then-write per cycle
// Purpose: holds one previous row; the read sees the old contents of the address being written.
// Ports: clk, i_we (write enable), i_addr (column), i_wdata (new pixel), o_rdata (stored pixel).
module conv_line_buffer #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  // Not reset: contents are always rewritten before they can reach a valid window.
  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  // Combinational read returns the pre-write value during a same-address write.
  assign o_rdata = r_mem[i_addr];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

endmodule

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster pixel stream to 3x3 sliding window generator
// Purpose: builds valid-only 3x3 windows from a W x H raster stream using two line buffers.
// Ports: clk, reset (sync, active-low),
//        bus (slave): start/cfg_width/cfg_height control, pix_in/pix_valid stream in,
//        win_out/win_valid window out, busy, frame_done pulse, cfg_err pulse.
module conv_window_gen
  import conv_window_gen_pkg::*;
#(
  parameter int MAX_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  conv_window_gen_if.slave     bus
);

  localparam int ADDR_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  logic                r_busy;
  logic [DIM_BIT-1:0]  r_col;
  logic [DIM_BIT-1:0]  r_row;
  logic [DIM_BIT-1:0]  r_w;
  logic [DIM_BIT-1:0]  r_h;
  logic [WIN_BIT-1:0]  r_win;
  logic                r_win_valid;
  logic                r_frame_done;
  logic                r_cfg_err;

  logic                w_cfg_ok;
  logic                w_start_ok;
  logic                w_accept;
  logic                w_col_last;
  logic                w_row_last;
  logic                w_win_done;
  logic [ADDR_W-1:0]   w_addr;
  logic [CELL_BIT-1:0] w_lb0_rd;
  logic [CELL_BIT-1:0] w_lb1_rd;
  logic [WIN_BIT-1:0]  w_win_next;

  assign w_cfg_ok   = (bus.cfg_width >= DIM_BIT'(3))
                    && ({{(32-DIM_BIT){1'b0}}, bus.cfg_width} <= MAX_W)
                    && (bus.cfg_height >= DIM_BIT'(3));
  assign w_start_ok = bus.start & w_cfg_ok;

  // start takes priority over a coincident pixel, which is dropped.
  assign w_accept   = bus.pix_valid & r_busy & ~bus.start;

  assign w_col_last = (r_col == r_w - DIM_BIT'(1));
  assign w_row_last = (r_row == r_h - DIM_BIT'(1));
  assign w_win_done = (r_row >= DIM_BIT'(2)) && (r_col >= DIM_BIT'(2));
  assign w_addr     = r_col[ADDR_W-1:0];

  // lb0 holds row r-1, lb1 holds row r-2; on each pixel the column ages one row.
  conv_line_buffer #(
    .DEPTH  (MAX_W),
    .ADDR_W (ADDR_W),
    .DATA_W (CELL_BIT)
  ) u_lb0 (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (w_addr),
    .i_wdata (bus.pix_in),
    .o_rdata (w_lb0_rd)
  );

  conv_line_buffer #(
    .DEPTH  (MAX_W),
    .ADDR_W (ADDR_W),
    .DATA_W (CELL_BIT)
  ) u_lb1 (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (w_addr),
    .i_wdata (w_lb0_rd),
    .o_rdata (w_lb1_rd)
  );

  // Shift the window one column left and insert the new column on the right.
  always_comb begin
    w_win_next = r_win;
    for (int r = 0; r < 3; r++) begin
      w_win_next[CELL_BIT*idx(r, 0) +: CELL_BIT] = r_win[CELL_BIT*idx(r, 1) +: CELL_BIT];
      w_win_next[CELL_BIT*idx(r, 1) +: CELL_BIT] = r_win[CELL_BIT*idx(r, 2) +: CELL_BIT];
    end
    w_win_next[CELL_BIT*idx(0, 2) +: CELL_BIT] = w_lb1_rd;
    w_win_next[CELL_BIT*idx(1, 2) +: CELL_BIT] = w_lb0_rd;
    w_win_next[CELL_BIT*idx(2, 2) +: CELL_BIT] = bus.pix_in;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy       <= 1'b0;
      r_col        <= '0;
      r_row        <= '0;
      r_w          <= '0;
      r_h          <= '0;
      r_win        <= '0;
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_cfg_err    <= bus.start & ~w_cfg_ok;

      if (w_start_ok) begin
        // Also serves as abort-and-restart when already busy.
        r_busy <= 1'b1;
        r_col  <= '0;
        r_row  <= '0;
        r_w    <= bus.cfg_width;
        r_h    <= bus.cfg_height;
      end else if (w_accept) begin
        r_win       <= w_win_next;
        r_win_valid <= w_win_done;
        if (w_col_last) begin
          r_col <= '0;
          r_row <= r_row + DIM_BIT'(1);
          if (w_row_last) begin
            r_busy       <= 1'b0;
            r_frame_done <= 1'b1;
          end
        end else begin
          r_col <= r_col + DIM_BIT'(1);
        end
      end
    end
  end

  assign bus.win_out    = r_win;
  assign bus.win_valid  = r_win_valid;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
  assign bus.cfg_err    = r_cfg_err;

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Upstream feeder for the 3x3 processing element. Takes a raster-order 8-bit feature-map pixel stream and builds 3x3 sliding windows using two line buffers.
- Presents each window as the PE's 72-bit activation bus, with a qualifying valid that drives the PE's en input.
- Valid convolution only (no padding): a W x H frame produces (W-2)*(H-2) windows.

Parameters:
- CELL_BIT, 8, pixel width (matches PE cell_bit)
- N_CELL, 9, cells per window (fixed 3x3; not overridable)
- MAX_W, 32, line-buffer depth = maximum frame width
- DIM_BIT, 6, width of the column/row counters and config fields

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset
- start  input  1  one-cycle pulse: latch cfg_width/cfg_height, clear counters, set busy
- cfg_width  input  DIM_BIT  frame width W in pixels
- cfg_height  input  DIM_BIT  frame height H in pixels
- pix_in  input  CELL_BIT  pixel data
- pix_valid  input  1  pix_in is valid this cycle
- win_out  output  CELL_BIT*N_CELL  3x3 window, packed as defined below
- win_valid  output  1  win_out holds a complete window this cycle
- busy  output  1  frame in progress
- frame_done  output  1  one-cycle pulse on the last window of a frame
- cfg_err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Reset (reset==0 at a posedge): win_out=0, win_valid=0, busy=0, frame_done=0, cfg_err=0, col=0, row=0. Line-buffer RAM is not cleared.
- Start acceptance:
  - start is accepted when 3<=cfg_width<=MAX_W and cfg_height>=3. On acceptance: W/H latched, col=row=0, busy=1.
  - If either condition fails: start is ignored, cfg_err=1 for one cycle, and busy/counters are unchanged.
  - start while busy with a legal config aborts the current frame and restarts it. No frame_done is issued for the aborted frame.
  - If start and pix_valid occur in the same cycle, start wins and that pixel is dropped.
- Accepted pixel = pix_valid & busy & ~start. While busy==0, pixels are ignored.
- On each accepted pixel:
  - Read lb1[col] (row r-2) and lb0[col] (row r-1).
  - Shift the 3x3 register one column left; the new right column is {top=lb1[col], mid=lb0[col], bot=pix_in}.
  - Write lb1[col]<=lb0[col] and lb0[col]<=pix_in.
  - Read-before-write at the same address within one cycle is required.
- Counters on an accepted pixel:
  - col increments and wraps to 0 at W-1.
  - row increments on that wrap.
  - After (row==H-1, col==W-1): busy<=0, frame_done<=1.
- Gaps (pix_valid=0) freeze all state, and win_valid is 0 in gap cycles.
- win_valid is registered and asserts the cycle after an accepted pixel with row>=2 && col>=2, for exactly one cycle per window. win_out changes only on accepted pixels.
- frame_done asserts in the same cycle as the final win_valid.
- Window packing: cell k = 3*r + c occupies bits [CELL_BIT*k+CELL_BIT-1 : CELL_BIT*k].
  - r=0 is the top (oldest) row; c=0 is the left (oldest) column.
  - Cell 0 is at the LSB.
- Latency: 1 cycle from the completing pixel to win_valid.
- No backpressure: the PE always consumes. Downstream pipeline depth is the PE's concern.
- Stale line-buffer data from an aborted or previous frame never appears in a valid window, because the row>=2 gating guarantees both buffers are rewritten first.

Decomposition:
- Shared package: CELL_BIT, N_CELL, the window cell-index function idx(r,c)=3*r+c, and DIM_BIT.
- One sub-module, conv_line_buffer: single-port-style read-then-write array of MAX_W x CELL_BIT, instantiated twice (lb0, lb1).
- Counters, the window shift register and control stay in conv_window_gen.

Test Plan:
- 4x4 frame, pixels 0..15, pix_valid continuous -> 4 win_valid pulses, each 1 cycle after pixels 10, 11, 14, 15.
  - First win_out cells 0..8 = 0,1,2,4,5,6,8,9,10.
  - Last window = 5,6,7,9,10,11,13,14,15.
  - frame_done coincides with the 4th pulse; busy falls.
- Same 4x4 frame with pix_valid toggling 1/0 -> identical window values and count; win_valid never high in gap cycles.
- start with cfg_width=2, then cfg_width=33, then cfg_height=2 -> three cfg_err pulses, busy stays 0, and pixels are ignored.
- 5x5 frame aborted by start after 12 pixels, then a fresh 5x5 frame of value 100+i -> 9 windows.
  - All cells come from the new frame; the first window is 100,101,102,105,106,107,110,111,112.
  - Only one frame_done is issued.
- reset low for one cycle mid-frame -> all outputs 0 next cycle, busy=0; the following start restarts cleanly.
- 32x3 frame (MAX_W) -> 30 windows, with column-address wrap at 31 correct. Checks: win_out for col=31 equals pixels {29,30,31, 61,62,63, 93,94,95}, each modulo 256.
